// File: rtl/ex_hazard_ctrl_pkg.sv
// ex_hazard_ctrl_pkg: forward-select and FSM encodings shared by the hazard controller.
package ex_hazard_ctrl_pkg;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MC_BUSY = 1'b1;
    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic stall_idex;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic mc_start;
        logic busy;
    } ctrl_t;
endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if: pipeline-state inputs and stall/flush/forward outputs of the hazard controller.
interface ex_hazard_ctrl_if;
    logic [2:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write, ex_multicycle;
    logic       mem_reg_write, wb_reg_write, branch_taken;
    logic [1:0] forward_a, forward_b;
    logic       stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem, mc_start, busy;
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_reg_write,
               ex_write_reg, ex_multicycle, mem_reg_write, wb_reg_write, mem_write_reg,
               wb_write_reg, branch_taken,
        output forward_a, forward_b, stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
               flush_exmem, mc_start, busy
    );
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_reg_write,
               ex_write_reg, ex_multicycle, mem_reg_write, wb_reg_write, mem_write_reg,
               wb_write_reg, branch_taken,
        input  forward_a, forward_b, stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
               flush_exmem, mc_start, busy
    );
endinterface

// File: rtl/ex_hazard_ctrl_fwd.sv
// ex_hazard_ctrl_fwd: operand forward select for one EX source; MEM beats WB, R0 never matches.
module ex_hazard_ctrl_fwd
    import ex_hazard_ctrl_pkg::*;
(
    input  logic [2:0] i_ex_reg,
    input  logic       i_mem_reg_write,
    input  logic [2:0] i_mem_write_reg,
    input  logic       i_wb_reg_write,
    input  logic [2:0] i_wb_write_reg,
    output logic [1:0] o_fwd
);
    assign o_fwd = (i_ex_reg == 3'd0) ? FWD_REG :
                   (i_mem_reg_write && i_mem_write_reg == i_ex_reg) ? FWD_MEM :
                   (i_wb_reg_write && i_wb_write_reg == i_ex_reg) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage forwarding, load-use bubble, branch flush and multi-cycle ALU stall control.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 4
) (
    input logic             clk,
    input logic             rst,
    ex_hazard_ctrl_if.slave bus
);
    logic [0:0] r_state;
    logic [3:0] r_mc_cnt;
    logic       w_load_use, w_idle, w_hold, w_br, w_mc, w_lu;
    ctrl_t      w_ctrl;

    ex_hazard_ctrl_fwd u_fwd_a (
        .i_ex_reg(bus.ex_rs), .i_mem_reg_write(bus.mem_reg_write), .i_mem_write_reg(bus.mem_write_reg),
        .i_wb_reg_write(bus.wb_reg_write), .i_wb_write_reg(bus.wb_write_reg), .o_fwd(bus.forward_a)
    );
    ex_hazard_ctrl_fwd u_fwd_b (
        .i_ex_reg(bus.ex_rt), .i_mem_reg_write(bus.mem_reg_write), .i_mem_write_reg(bus.mem_write_reg),
        .i_wb_reg_write(bus.wb_reg_write), .i_wb_write_reg(bus.wb_write_reg), .o_fwd(bus.forward_b)
    );

    assign w_load_use = bus.ex_mem_read && bus.ex_write_reg != 3'd0 &&
                        ((bus.id_uses_rs && bus.id_rs == bus.ex_write_reg) ||
                         (bus.id_uses_rt && bus.id_rt == bus.ex_write_reg));
    assign w_idle = r_state == S_IDLE;
    // the final MC_BUSY cycle (count exhausted) releases the pipeline
    assign w_hold = r_state == S_MC_BUSY && r_mc_cnt != 4'd0;
    assign w_br   = w_idle && bus.branch_taken;
    assign w_mc   = w_idle && !bus.branch_taken && bus.ex_multicycle;
    assign w_lu   = w_idle && !bus.branch_taken && !bus.ex_multicycle && w_load_use;

    always_comb begin
        w_ctrl = '0;
        if (!rst) begin
            w_ctrl.stall_pc    = w_mc || w_hold || w_lu;
            w_ctrl.stall_ifid  = w_mc || w_hold || w_lu;
            w_ctrl.stall_idex  = w_mc || w_hold;
            w_ctrl.flush_ifid  = w_br;
            w_ctrl.flush_idex  = w_br || w_lu;
            w_ctrl.flush_exmem = w_mc || w_hold;
            w_ctrl.mc_start    = w_mc;
            w_ctrl.busy        = w_hold;
        end
    end

    assign bus.stall_pc    = w_ctrl.stall_pc;
    assign bus.stall_ifid  = w_ctrl.stall_ifid;
    assign bus.stall_idex  = w_ctrl.stall_idex;
    assign bus.flush_ifid  = w_ctrl.flush_ifid;
    assign bus.flush_idex  = w_ctrl.flush_idex;
    assign bus.flush_exmem = w_ctrl.flush_exmem;
    assign bus.mc_start    = w_ctrl.mc_start;
    assign bus.busy        = w_ctrl.busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mc_cnt <= 4'd0;
        end else if (w_mc) begin
            r_state  <= S_MC_BUSY;
            r_mc_cnt <= 4'(MC_LATENCY - 2);
        end else if (r_state == S_MC_BUSY) begin
            if (r_mc_cnt == 4'd0) r_state <= S_IDLE;
            else r_mc_cnt <= r_mc_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed vectors queue expected outputs; a negedge monitor pops and compares.
module tb_ex_hazard_ctrl;
    typedef struct {
        string      n;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [7:0] c;
    } exp_t;

    // ctrl bit order: stall_pc stall_ifid stall_idex flush_ifid flush_idex flush_exmem mc_start busy
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_BR   = 8'b0001_1000;
    localparam logic [7:0] C_MCS  = 8'b1110_0110;
    localparam logic [7:0] C_MCB  = 8'b1110_0101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   n_run = 0;
    int   n_fail = 0;

    ex_hazard_ctrl_if bus ();
    ex_hazard_ctrl #(.MC_LATENCY(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = q.pop_front();
            act = {bus.stall_pc, bus.stall_ifid, bus.stall_idex, bus.flush_ifid,
                   bus.flush_idex, bus.flush_exmem, bus.mc_start, bus.busy};
            n_run++;
            if (bus.forward_a !== e.fa || bus.forward_b !== e.fb || act !== e.c) begin
                n_fail++;
                $display("FAIL %s: got fa=%b fb=%b ctrl=%b, want fa=%b fb=%b ctrl=%b",
                         e.n, bus.forward_a, bus.forward_b, act, e.fa, e.fb, e.c);
            end
        end
    end

    task automatic clr();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_mem_read = 0; bus.ex_reg_write = 0;
        bus.ex_write_reg = 0; bus.ex_multicycle = 0; bus.mem_reg_write = 0;
        bus.wb_reg_write = 0; bus.mem_write_reg = 0; bus.wb_write_reg = 0; bus.branch_taken = 0;
    endtask

    task automatic chk(input string n, input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] c);
        q.push_back('{n, fa, fb, c});
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        bus.ex_mem_read = 1; bus.ex_write_reg = 2; bus.id_rs = 2; bus.id_uses_rs = 1;
    endtask

    initial begin
        clr();
        @(posedge clk);
        #1;
        set_lu(); bus.ex_multicycle = 1;
        chk("reset_0", 2'b00, 2'b00, C_NONE);
        chk("reset_1", 2'b00, 2'b00, C_NONE);
        rst = 0; clr();
        chk("idle", 2'b00, 2'b00, C_NONE);
        bus.ex_rs = 3; bus.mem_write_reg = 3; bus.mem_reg_write = 1; bus.wb_write_reg = 3; bus.wb_reg_write = 1;
        chk("fwd_mem_prio", 2'b01, 2'b00, C_NONE);
        bus.ex_rs = 0;
        chk("fwd_r0", 2'b00, 2'b00, C_NONE);
        clr(); bus.ex_rs = 5; bus.mem_write_reg = 5; bus.wb_write_reg = 5; bus.wb_reg_write = 1;
        chk("fwd_wb", 2'b10, 2'b00, C_NONE);
        clr(); bus.ex_rs = 6; bus.ex_rt = 6; bus.mem_write_reg = 6; bus.mem_reg_write = 1;
        chk("fwd_both_mem", 2'b01, 2'b01, C_NONE);
        clr(); bus.ex_rs = 2; bus.ex_rt = 7; bus.mem_write_reg = 1; bus.mem_reg_write = 1;
        bus.wb_write_reg = 7; bus.wb_reg_write = 1;
        chk("fwd_b_wb", 2'b00, 2'b10, C_NONE);
        clr(); set_lu();
        chk("load_use_rs", 2'b00, 2'b00, C_LU);
        clr();
        chk("load_use_after", 2'b00, 2'b00, C_NONE);
        set_lu(); bus.id_uses_rs = 0;
        chk("load_use_unused", 2'b00, 2'b00, C_NONE);
        clr(); bus.ex_mem_read = 1; bus.ex_write_reg = 2; bus.id_rt = 2; bus.id_uses_rt = 1;
        chk("load_use_rt", 2'b00, 2'b00, C_LU);
        clr(); bus.ex_mem_read = 1; bus.ex_write_reg = 0; bus.id_rs = 0; bus.id_uses_rs = 1;
        chk("load_use_r0", 2'b00, 2'b00, C_NONE);
        clr(); set_lu(); bus.branch_taken = 1;
        chk("branch_over_lu", 2'b00, 2'b00, C_BR);
        clr(); bus.ex_multicycle = 1; bus.ex_rs = 3; bus.mem_write_reg = 3; bus.mem_reg_write = 1;
        chk("mc_c0", 2'b01, 2'b00, C_MCS);
        bus.branch_taken = 1; set_lu();
        chk("mc_c1", 2'b01, 2'b00, C_MCB);
        chk("mc_c2", 2'b01, 2'b00, C_MCB);
        chk("mc_c3", 2'b01, 2'b00, C_NONE);
        clr(); bus.branch_taken = 1;
        chk("mc_then_branch", 2'b00, 2'b00, C_BR);
        clr(); bus.ex_multicycle = 1; bus.branch_taken = 1;
        chk("mc_vs_branch", 2'b00, 2'b00, C_BR);
        clr();
        chk("mc_vs_branch_after", 2'b00, 2'b00, C_NONE);
        bus.ex_multicycle = 1;
        chk("rst_mc_c0", 2'b00, 2'b00, C_MCS);
        chk("rst_mc_c1", 2'b00, 2'b00, C_MCB);
        rst = 1;
        chk("rst_mc_c2", 2'b00, 2'b00, C_NONE);
        rst = 0;
        chk("restart_c0", 2'b00, 2'b00, C_MCS);
        chk("restart_c1", 2'b00, 2'b00, C_MCB);
        chk("restart_c2", 2'b00, 2'b00, C_MCB);
        chk("restart_c3", 2'b00, 2'b00, C_NONE);
        clr();
        chk("final_idle", 2'b00, 2'b00, C_NONE);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_LATENCY, default 4, total EX-stage cycles of a multi-cycle ALU op (legal 2..15).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports id_rs, id_rt, input, 3 each, source registers of the instruction in ID.
REQ-005 SHALL have ports id_uses_rs, id_uses_rt, input, 1 each, ID instruction actually reads that source.
REQ-006 SHALL have ports ex_rs, ex_rt, input, 3 each, source registers of the instruction in EX.
REQ-007 SHALL have ports ex_mem_read, ex_reg_write, input, 1 each; ex_write_reg, input, 3, EX destination.
REQ-008 SHALL have port ex_multicycle, input, 1, EX instruction is a multi-cycle ALU op.
REQ-009 SHALL have ports mem_reg_write, wb_reg_write, input, 1 each; mem_write_reg, wb_write_reg, input, 3 each.
REQ-010 SHALL have port branch_taken, input, 1, branch/jump resolved taken in EX.
REQ-011 SHALL have ports forward_a, forward_b, output, 2 each, EX operand select: 00 register file, 01 MEM data, 10 WB data.
REQ-012 SHALL have outputs stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem, mc_start, busy, 1 each.

Function
REQ-013 forward_a SHALL be 01 when mem_reg_write, mem_write_reg==ex_rs, ex_rs!=0; else 10 when wb_reg_write, wb_write_reg==ex_rs, ex_rs!=0; else 00 (combinational, MEM priority over WB).
REQ-014 forward_b SHALL follow REQ-013 using ex_rt.
REQ-015 R0 SHALL never be a forwarding or hazard match.
REQ-016 FSM states SHALL be IDLE, MC_BUSY; 4-bit down-counter mc_cnt.
REQ-017 Load-use hazard SHALL be: ex_mem_read & ex_write_reg!=0 & ((id_uses_rs & id_rs==ex_write_reg) | (id_uses_rt & id_rt==ex_write_reg)).
REQ-018 In IDLE with load-use and no branch_taken: stall_pc=stall_ifid=flush_idex=1 for that cycle only (one bubble).
REQ-019 In IDLE with branch_taken: flush_ifid=flush_idex=1, stalls 0; branch_taken overrides load-use.
REQ-020 In IDLE with ex_multicycle and no branch_taken: mc_start=1 one cycle, next state MC_BUSY, mc_cnt loaded MC_LATENCY-2.
REQ-021 The mc_start cycle and every MC_BUSY cycle SHALL assert stall_pc, stall_ifid, stall_idex, flush_exmem; busy=1 in MC_BUSY.
REQ-022 MC_BUSY SHALL decrement mc_cnt; at mc_cnt==0 it drops stalls/flushes that cycle and returns to IDLE next edge (total EX occupancy exactly MC_LATENCY cycles).
REQ-023 In MC_BUSY, load-use, branch_taken and ex_multicycle SHALL be ignored; evaluated only after return to IDLE.
REQ-024 Multi-cycle op and taken branch in same IDLE cycle: branch wins, no mc_start.
REQ-025 Forwarding outputs SHALL remain valid during MC_BUSY (held EX instruction).

Reset
REQ-026 rst=1 SHALL force IDLE, mc_cnt=0, all 1-bit outputs 0 at next edge, including mid-MC_BUSY.
REQ-027 First cycle after rst deassert SHALL evaluate hazards normally.

Structure
REQ-028 Forward-select encodings (FWD_REG, FWD_MEM, FWD_WB) and state encodings SHALL live in shared defines.v.
REQ-029 Single module; optional sub-module fwd_unit for REQ-013/014 combinational logic.

Verification
REQ-030 ex_rs=3, mem_write_reg=3 mem_reg_write=1, wb_write_reg=3 wb_reg_write=1 -> forward_a=01; ex_rs=0 same -> 00.
REQ-031 ex_mem_read=1 ex_write_reg=2, id_rs=2 id_uses_rs=1 -> one cycle stall_pc=stall_ifid=flush_idex=1, then 0.
REQ-032 Same as 031 plus branch_taken=1 -> flush_ifid=flush_idex=1, stall_pc=0.
REQ-033 ex_multicycle=1, MC_LATENCY=4 -> mc_start 1 cycle, stall_idex high cycles 0..2, low cycle 3, busy cycles 1..2.
REQ-034 rst pulsed during MC_BUSY cycle 2 -> all outputs 0 next edge, state IDLE, new op restarts full count.
